// File: rtl/delay_line.sv
// Enable-gated pipeline of DEPTH registered stages, each carrying WIDTH data bits and a valid bit,
// with flush, a running occupancy count and an optional output tap (enabled by DELAY_LINE_TAP_EN).
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       flush,
  input  logic [$clog2(DEPTH)-1:0]   tap_sel,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int SW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_tap [DEPTH];
  logic [DEPTH-1:0] valid_tap;
  logic [WIDTH-1:0] stage_din [DEPTH];
  logic [DEPTH-1:0] stage_vin;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;

  assign stage_din[0] = din;
  assign stage_vin[0] = din_valid;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_chain
      assign stage_din[gi] = data_tap[gi-1];
      assign stage_vin[gi] = valid_tap[gi-1];
    end

    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] data_reg;
      logic             valid_reg;

      // Flush clears only the valid bits; data keeps its last value.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else if (flush) begin
          valid_reg <= 1'b0;
        end else if (en) begin
          data_reg  <= stage_din[gi];
          valid_reg <= stage_vin[gi];
        end
      end

      assign data_tap[gi]  = data_reg;
      assign valid_tap[gi] = valid_reg;
    end
  endgenerate

  // Occupancy is tracked incrementally: +1 for a valid sample in, -1 for a valid sample out.
  always_comb begin
    count_next = count_reg;
    if (en) begin
      count_next = count_reg + CW'(din_valid) - CW'(valid_tap[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (flush) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

`ifdef DELAY_LINE_TAP_EN
  logic [SW-1:0] sel_idx;

  // Out-of-range selects (non-power-of-two DEPTH) fall back to the last stage.
  always_comb begin
    sel_idx = tap_sel;
    if (tap_sel > SW'(DEPTH-1)) begin
      sel_idx = SW'(DEPTH-1);
    end
  end

  assign dout       = data_tap[sel_idx];
  assign dout_valid = valid_tap[sel_idx];
`else
  logic unused_tap_sel;

  assign unused_tap_sel = ^tap_sel;
  assign dout           = data_tap[DEPTH-1];
  assign dout_valid     = valid_tap[DEPTH-1];
`endif

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: directed scenarios followed by random traffic, all checked
// against a history-queue reference model (tap checks run when DELAY_LINE_TAP_EN is defined).
module tb_delay_line;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int TW = $clog2(D);
  localparam int CW = $clog2(D+1);

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } ent_t;

  logic          clk;
  logic          rst;
  logic          en;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          flush;
  logic [TW-1:0] tap_sel;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int vectors = 0;
  int miscompares = 0;
  int step_no = 0;

  // Model: newest accepted entry at index 0; entries older than D enabled edges are dropped.
  ent_t hist[$];

  delay_line #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid), .flush(flush),
    .tap_sel(tap_sel), .dout(dout), .dout_valid(dout_valid), .count(count),
    .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_sel();
`ifdef DELAY_LINE_TAP_EN
    return (int'(tap_sel) > D-1) ? D-1 : int'(tap_sel);
`else
    return D-1;
`endif
  endfunction

  function automatic int model_count();
    int n = 0;
    foreach (hist[i]) if (hist[i].v) n++;
    return n;
  endfunction

  task automatic model_edge(input logic r, input logic f, input logic e,
                            input logic [W-1:0] di, input logic dv);
    ent_t x;
    if (r) begin
      hist.delete();
    end else if (f) begin
      foreach (hist[i]) hist[i].v = 1'b0;
    end else if (e) begin
      x.v = dv;
      x.d = di;
      hist.push_front(x);
      if (hist.size() > D) void'(hist.pop_back());
    end
  endtask

  task automatic check_all(input string tag);
    int s;
    logic [W-1:0]  exp_d;
    logic          exp_v;
    logic [CW-1:0] exp_c;
    s = model_sel();
    exp_d = (s < hist.size()) ? hist[s].d : '0;
    exp_v = (s < hist.size()) ? hist[s].v : 1'b0;
    exp_c = CW'(model_count());
    vectors++;
    assert (dout === exp_d) else begin
      miscompares++;
      $error("FAIL %s dout: got %h expected %h", tag, dout, exp_d);
    end
    vectors++;
    assert (dout_valid === exp_v) else begin
      miscompares++;
      $error("FAIL %s dout_valid: got %b expected %b", tag, dout_valid, exp_v);
    end
    vectors++;
    assert (count === exp_c) else begin
      miscompares++;
      $error("FAIL %s count: got %0d expected %0d", tag, count, exp_c);
    end
    vectors++;
    assert (full === (exp_c == CW'(D))) else begin
      miscompares++;
      $error("FAIL %s full: got %b expected %b", tag, full, (exp_c == CW'(D)));
    end
    vectors++;
    assert (empty === (exp_c == '0)) else begin
      miscompares++;
      $error("FAIL %s empty: got %b expected %b", tag, empty, (exp_c == '0));
    end
  endtask

  task automatic step(input string tag, input logic r, input logic f, input logic e,
                      input logic [W-1:0] di, input logic dv);
    rst = r; flush = f; en = e; din = di; din_valid = dv;
    @(posedge clk);
    model_edge(r, f, e, di, dv);
    #1;
    step_no++;
    $display("step %0d %s rst=%b flush=%b en=%b din=%h dv=%b tap=%0d -> dout=%h dv=%b count=%0d",
             step_no, tag, r, f, e, di, dv, tap_sel, dout, dout_valid, count);
    check_all(tag);
  endtask

  task automatic expect_val(input string tag, input int got, input int exp);
    vectors++;
    assert (got == exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++)
      step("reset", 1'b1, 1'($urandom), 1'($urandom), W'($urandom), 1'($urandom));
  endtask

  initial begin
    logic [W-1:0] fill_vals [5];
    fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rst = 1'b1; flush = 1'b0; en = 1'b0; din = '0; din_valid = 1'b0;
    tap_sel = TW'(D-1);

    // Reset with random inputs: explicit reset values as well as the model.
    do_reset();
    expect_val("reset_dout", int'(dout), 0);
    expect_val("reset_empty", int'(empty), 1);

    // Fill and latency.
    for (int i = 0; i < 5; i++) begin
      step("fill", 1'b0, 1'b0, 1'b1, fill_vals[i], 1'b1);
      if (i == 3) expect_val("fill_first_out", int'(dout), 8'h11);
    end
    expect_val("fill_count", int'(count), 4);
    expect_val("fill_full", int'(full), 1);

    // Stall: two entries, three disabled cycles, then resume.
    do_reset();
    step("stall_in", 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1);
    step("stall_in", 1'b0, 1'b0, 1'b1, 8'hA2, 1'b1);
    for (int i = 0; i < 3; i++)
      step("stall_hold", 1'b0, 1'b0, 1'b0, W'($urandom), 1'($urandom));
    expect_val("stall_count", int'(count), 2);
    step("stall_resume", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    step("stall_resume", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    expect_val("stall_exit", int'(dout), 8'hA1);

    // Bubbles: valid pattern 1,0,1,0 then more bubbles to drain.
    do_reset();
    for (int i = 0; i < 8; i++)
      step("bubble", 1'b0, 1'b0, 1'b1, W'(8'hB0 + i), (i < 4) ? 1'(~i[0]) : 1'b0);

    // Flush collision with a full pipeline.
    for (int i = 0; i < 4; i++)
      step("pre_flush", 1'b0, 1'b0, 1'b1, W'(8'hC0 + i), 1'b1);
    step("flush", 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1);
    expect_val("flush_count", int'(count), 0);
    expect_val("flush_valid", int'(dout_valid), 0);
    for (int i = 0; i < 4; i++)
      step("post_flush", 1'b0, 1'b0, 1'b1, W'(8'hD0 + i), 1'b0);

`ifdef DELAY_LINE_TAP_EN
    // Tap: short latency at stage 1, then switch taps mid-stream.
    do_reset();
    tap_sel = 1;
    for (int i = 1; i <= 4; i++) begin
      step("tap1", 1'b0, 1'b0, 1'b1, W'(i), 1'b1);
      if (i == 2) expect_val("tap1_latency", int'(dout), 1);
    end
    tap_sel = 3;
    #1;
    check_all("tap_switch");
    expect_val("tap_switch_d3", int'(dout), 1);
`endif

    // Random traffic, occasional flush/reset, random tap selection.
    for (int i = 0; i < 300; i++) begin
      tap_sel = TW'($urandom_range(0, D-1));
      step("random", ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
